// File: rtl/bin2gray_counter.sv
// Binary up/down counter with registered Gray-code output, one-cycle wrap pulse
// and a sticky flag raised if a counting step ever changes other than one Gray bit.
module bin2gray_counter #(
   parameter int SIZE = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [SIZE-1:0] bin_in,
   input  logic            en,
   input  logic            up,
   output logic [SIZE-1:0] bin_out,
   output logic [SIZE-1:0] gray_out,
   output logic            valid_out,
   output logic            wrap,
   output logic            step_err
);

   localparam logic [SIZE-1:0] ONE      = {{(SIZE-1){1'b0}}, 1'b1};
   localparam logic [SIZE-1:0] ALL_ONES = {SIZE{1'b1}};
   localparam logic [SIZE-1:0] ZERO     = {SIZE{1'b0}};

   logic [SIZE-1:0] r_bin;
   logic [SIZE-1:0] r_gray;
   logic            r_valid;
   logic            r_wrap;
   logic            r_step_err;

   logic [SIZE-1:0] w_cnt_next;
   logic [SIZE-1:0] w_gray_next;
   logic [SIZE-1:0] w_gray_diff;
   logic            w_step;
   logic            w_wrap_next;
   logic            w_one_bit;

   always_comb begin
      w_cnt_next = r_bin;
      w_step     = 1'b0;
      if (load) begin
         w_cnt_next = bin_in;
      end else if (en) begin
         w_step     = 1'b1;
         w_cnt_next = up ? (r_bin + ONE) : (r_bin - ONE);
      end
   end

   // Wrap only on a real count step crossing the boundary, never on load.
   assign w_wrap_next = w_step & ((up & (r_bin == ALL_ONES)) | (~up & (r_bin == ZERO)));

   genvar gi;
   generate
      for (gi = 0; gi < SIZE - 1; gi++) begin : g_gray
         assign w_gray_next[gi] = w_cnt_next[gi] ^ w_cnt_next[gi+1];
      end
   endgenerate
   assign w_gray_next[SIZE-1] = w_cnt_next[SIZE-1];

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign w_gray_diff = w_gray_next ^ r_gray;
   assign w_one_bit   = (w_gray_diff != ZERO) && ((w_gray_diff & (w_gray_diff - ONE)) == ZERO);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin      <= ZERO;
         r_gray     <= ZERO;
         r_valid    <= 1'b0;
         r_wrap     <= 1'b0;
         r_step_err <= 1'b0;
      end else begin
         r_bin  <= w_cnt_next;
         r_gray <= w_gray_next;
         r_wrap <= w_wrap_next;
         if (load || en) begin
            r_valid <= 1'b1;
         end
         if (w_step && !w_one_bit) begin
            r_step_err <= 1'b1;
         end
      end
   end

   assign bin_out   = r_bin;
   assign gray_out  = r_gray;
   assign valid_out = r_valid;
   assign wrap      = r_wrap;
   assign step_err  = r_step_err;

endmodule

// File: tb/tb_bin2gray_counter.sv
// Scoreboard bench for bin2gray_counter: stimulus pushes model predictions,
// a monitor pops and compares them one cycle after each clock edge.
module tb_bin2gray_counter;

   localparam int SIZE = 10;
   localparam int N    = 1 << SIZE;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            load = 1'b0;
   logic [SIZE-1:0] bin_in = '0;
   logic            en = 1'b0;
   logic            up = 1'b0;
   logic [SIZE-1:0] bin_out;
   logic [SIZE-1:0] gray_out;
   logic            valid_out;
   logic            wrap;
   logic            step_err;

   bin2gray_counter #(.SIZE(SIZE)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .bin_in    (bin_in),
      .en        (en),
      .up        (up),
      .bin_out   (bin_out),
      .gray_out  (gray_out),
      .valid_out (valid_out),
      .wrap      (wrap),
      .step_err  (step_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    cyc;
      int    bin;
      int    gray;
      bit    valid;
      bit    wrap;
      bit    err;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_cycle  = 0;

   // Reference model state (plain integer arithmetic).
   int   m_cnt   = 0;
   bit   m_valid = 0;
   bit   m_wrap  = 0;
   bit   m_err   = 0;

   task automatic chk(input string name, input int cyc, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
   endtask

   function automatic int gray_decode(input int g);
      int d = 0;
      for (int k = 0; k < SIZE; k++) d = d ^ (g >> k);
      return d & (N - 1);
   endfunction

   task automatic drive(input bit r, input bit l, input int b, input bit e, input bit u);
      exp_t x;
      @(posedge clk);
      #2;
      rst = r; load = l; bin_in = b[SIZE-1:0]; en = e; up = u;
      n_cycle++;
      if (r) begin
         m_cnt = 0; m_valid = 0; m_wrap = 0; m_err = 0;
      end else if (l) begin
         m_cnt = b % N; m_valid = 1; m_wrap = 0;
      end else if (e) begin
         m_wrap  = u ? (m_cnt == N - 1) : (m_cnt == 0);
         m_cnt   = u ? (m_cnt + 1) % N : (m_cnt + N - 1) % N;
         m_valid = 1;
      end else begin
         m_wrap = 0;
      end
      x.cyc = n_cycle; x.bin = m_cnt; x.gray = m_cnt ^ (m_cnt >> 1);
      x.valid = m_valid; x.wrap = m_wrap; x.err = m_err;
      q.push_back(x);
   endtask

   // Monitor: DUT presents a new output every cycle, sampled 1 time unit after the edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            chk("bin_out",   x.cyc, int'(bin_out),   x.bin);
            chk("gray_out",  x.cyc, int'(gray_out),  x.gray);
            chk("gray_dec",  x.cyc, gray_decode(int'(gray_out)), x.bin);
            chk("valid_out", x.cyc, int'(valid_out), int'(x.valid));
            chk("wrap",      x.cyc, int'(wrap),      int'(x.wrap));
            chk("step_err",  x.cyc, int'(step_err),  int'(x.err));
            $display("cyc %0d bin=0x%03h gray=0x%03h valid=%0b wrap=%0b err=%0b",
                     x.cyc, bin_out, gray_out, valid_out, wrap, step_err);
         end
      end
   end

   initial begin
      int r;
      // Reset then idle
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      repeat (5) drive(0, 0, 0, 0, 0);
      // Load encodings
      drive(0, 1, 5, 0, 0);
      drive(0, 1, 'h155, 0, 0);
      drive(0, 1, 'h3FF, 0, 0);
      // Up wrap then next step
      drive(0, 0, 0, 1, 1);
      drive(0, 0, 0, 1, 1);
      // Down wrap and direction flip from 0
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 1);
      // Full up sweep from 0
      drive(0, 1, 0, 0, 0);
      for (int i = 0; i < N; i++) drive(0, 0, 0, 1, 1);
      // Priority: load beats en at the boundary
      drive(0, 1, 'h3FE, 0, 0);
      drive(0, 1, 'h3FF, 1, 1);
      // Reset together with load
      drive(1, 1, 'h123, 1, 1);
      drive(0, 0, 0, 0, 0);
      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2)       drive(1, $urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
         else if (r < 12) drive(0, 1, ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? N - 1 : 0)
                                                                  : int'($urandom_range(0, N - 1)),
                                $urandom_range(0, 1), $urandom_range(0, 1));
         else if (r < 80) drive(0, 0, $urandom, 1, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
         else             drive(0, 0, $urandom, 0, $urandom_range(0, 1));
      end
      drive(0, 0, 0, 0, 0);
      // Drain scoreboard with a bounded wait
      for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
      #2;
      if (q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
